// File: rtl/csla_pipe_adder.sv
// csla_pipe_adder
// Pipelined carry-select adder/subtractor. The operand is cut into BLOCK-bit
// blocks; block 0 ripples from the effective carry-in, every higher block
// precomputes sums for carry-in 0 and 1 and selects on the incoming carry.
// A register stage follows every BLOCKS_PER_STAGE blocks. Operands travel
// alongside the partial sum until their stage consumes them. All stages
// advance together under a single enable (global stall).
module csla_pipe_adder #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned BLOCK            = 4,
  parameter int unsigned BLOCKS_PER_STAGE = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_summ,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int unsigned NBLK = WIDTH / BLOCK;
  localparam int unsigned LAT  = NBLK / BLOCKS_PER_STAGE;

  logic en;

  // Stage output registers, index k = register bank after stage k
  logic             v_q   [LAT];
  logic [WIDTH-1:0] s_q   [LAT];
  logic             c_q   [LAT];
  logic [WIDTH-1:0] a_q   [LAT];
  logic [WIDTH-1:0] b_q   [LAT];
  logic             sub_q [LAT];
  logic             ovf_q;

  // Stage inputs
  logic             v_in   [LAT];
  logic [WIDTH-1:0] s_in   [LAT];
  logic             c_in   [LAT];
  logic [WIDTH-1:0] a_in   [LAT];
  logic [WIDTH-1:0] b_in   [LAT];
  logic             sub_in [LAT];

  // Stage results, loaded into the registers on en
  logic             v_n   [LAT];
  logic [WIDTH-1:0] s_n   [LAT];
  logic             c_n   [LAT];
  logic [WIDTH-1:0] a_n   [LAT];
  logic [WIDTH-1:0] b_n   [LAT];
  logic             sub_n [LAT];
  logic             ovf_n;

  assign en         = ~o_valid | i_ready;
  assign o_ready    = en;
  assign o_valid    = v_q[LAT-1];
  assign o_summ     = s_q[LAT-1];
  assign o_carry    = c_q[LAT-1];
  assign o_overflow = ovf_q;

  // Route primary inputs to stage 0 and each register bank to the next stage
  always_comb begin
    v_in[0]   = i_valid;
    s_in[0]   = '0;
    c_in[0]   = i_carry ^ i_sub;
    a_in[0]   = i_a;
    b_in[0]   = i_b;
    sub_in[0] = i_sub;
    for (int unsigned k = 1; k < LAT; k++) begin
      v_in[k]   = v_q[k-1];
      s_in[k]   = s_q[k-1];
      c_in[k]   = c_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      sub_in[k] = sub_q[k-1];
    end
  end

  // Evaluate each stage's blocks: ripple for block 0, carry-select elsewhere
  always_comb begin : stage_eval
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [BLOCK:0]   r0;
    logic [BLOCK:0]   r1;
    logic [BLOCK:0]   sel;
    int unsigned      lo;
    b_eff = '0;
    sum   = '0;
    carry = 1'b0;
    r0    = '0;
    r1    = '0;
    sel   = '0;
    lo    = 0;
    ovf_n = 1'b0;
    for (int unsigned k = 0; k < LAT; k++) begin
      b_eff = b_in[k] ^ {WIDTH{sub_in[k]}};
      sum   = s_in[k];
      carry = c_in[k];
      for (int unsigned j = 0; j < BLOCKS_PER_STAGE; j++) begin
        lo = (k * BLOCKS_PER_STAGE + j) * BLOCK;
        if (k == 0 && j == 0) begin
          sel = {1'b0, a_in[k][lo +: BLOCK]} + {1'b0, b_eff[lo +: BLOCK]}
              + {{BLOCK{1'b0}}, carry};
        end else begin
          r0  = {1'b0, a_in[k][lo +: BLOCK]} + {1'b0, b_eff[lo +: BLOCK]};
          r1  = {1'b0, a_in[k][lo +: BLOCK]} + {1'b0, b_eff[lo +: BLOCK]}
              + {{BLOCK{1'b0}}, 1'b1};
          sel = carry ? r1 : r0;
        end
        sum[lo +: BLOCK] = sel[BLOCK-1:0];
        carry            = sel[BLOCK];
      end
      v_n[k]   = v_in[k];
      s_n[k]   = sum;
      c_n[k]   = carry;
      a_n[k]   = a_in[k];
      b_n[k]   = b_in[k];
      sub_n[k] = sub_in[k];
      // carry into the MSB is recovered from the MSB's sum bit and operands
      if (k == LAT - 1) begin
        ovf_n = carry ^ (a_in[k][WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]);
      end
    end
  end

  // Pipeline registers: clear on reset, advance together when en is high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        v_q[k]   <= 1'b0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sub_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        v_q[k]   <= v_n[k];
        s_q[k]   <= s_n[k];
        c_q[k]   <= c_n[k];
        a_q[k]   <= a_n[k];
        b_q[k]   <= b_n[k];
        sub_q[k] <= sub_n[k];
      end
      ovf_q <= ovf_n;
    end
  end

endmodule

// File: tb/tb_csla_pipe_adder.sv
// Testbench for csla_pipe_adder: directed add/subtract vectors, reset,
// bubbles, stalled back-to-back stream, and a sweep over two other
// parameter sets against a behavioural golden model.
module tb_csla_pipe_adder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;
  localparam int LAT2 = 8;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default configuration (LAT = 4)
  logic        v0 = 0, rdy0 = 1, cin0 = 0, sub0 = 0;
  logic [31:0] a0 = '0, b0 = '0;
  logic        ordy0, ov0, co0, of0;
  logic [31:0] sum0;

  // WIDTH 32, BLOCK 8, BLOCKS_PER_STAGE 4 (LAT = 1)
  logic        v1 = 0, rdy1 = 1, cin1 = 0, sub1 = 0;
  logic [31:0] a1 = '0, b1 = '0;
  logic        ordy1, ov1, co1, of1;
  logic [31:0] sum1;

  // WIDTH 16, BLOCK 2, BLOCKS_PER_STAGE 1 (LAT = 8)
  logic        v2 = 0, rdy2 = 1, cin2 = 0, sub2 = 0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        ordy2, ov2, co2, of2;
  logic [15:0] sum2;

  csla_pipe_adder #(.WIDTH(32), .BLOCK(4), .BLOCKS_PER_STAGE(2)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .o_ready(ordy0),
    .i_a(a0), .i_b(b0), .i_carry(cin0), .i_sub(sub0),
    .o_valid(ov0), .i_ready(rdy0), .o_summ(sum0), .o_carry(co0), .o_overflow(of0));

  csla_pipe_adder #(.WIDTH(32), .BLOCK(8), .BLOCKS_PER_STAGE(4)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(ordy1),
    .i_a(a1), .i_b(b1), .i_carry(cin1), .i_sub(sub1),
    .o_valid(ov1), .i_ready(rdy1), .o_summ(sum1), .o_carry(co1), .o_overflow(of1));

  csla_pipe_adder #(.WIDTH(16), .BLOCK(2), .BLOCKS_PER_STAGE(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(ordy2),
    .i_a(a2), .i_b(b2), .i_carry(cin2), .i_sub(sub2),
    .o_valid(ov2), .i_ready(rdy2), .o_summ(sum2), .o_carry(co2), .o_overflow(of2));

  // Behavioural reference for a w-bit adder/subtractor (w <= 32)
  function automatic exp_t gold(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub);
    exp_t        e;
    logic [31:0] mask;
    logic [31:0] am;
    logic [31:0] be;
    logic [32:0] full;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am     = a & mask;
    be     = (b ^ {32{sub}}) & mask;
    full   = {1'b0, am} + {1'b0, be} + {32'd0, cin ^ sub};
    e.s    = full[31:0] & mask;
    e.c    = full[w];
    e.o    = (am[w-1] == be[w-1]) && (e.s[w-1] != am[w-1]);
    e.acc  = 0;
    return e;
  endfunction

  function automatic logic [31:0] rnd_op(input int w);
    logic [31:0] mask;
    int unsigned r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r    = $urandom_range(0, 7);
    if (r == 0) return 32'd0;
    if (r == 1) return mask;
    return $urandom & mask;
  endfunction

  task automatic test_reset();
    #3;
    checks++;
    if (ov0 !== 1'b0 || sum0 !== 32'd0 || co0 !== 1'b0 || of0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut0: valid=%b summ=%h carry=%b ovf=%b, required 0/0/0/0", ov0, sum0, co0, of0);
    end
    checks++;
    if (ov1 !== 1'b0 || ov2 !== 1'b0 || sum1 !== 32'd0 || sum2 !== 16'd0) begin
      errors++;
      $display("FAIL reset_sweep_duts: valid1=%b valid2=%b summ1=%h summ2=%h, required zeros", ov1, ov2, sum1, sum2);
    end
    checks++;
    if (ordy0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: o_ready=%b, required 1", ordy0);
    end
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Single operation on dut0 with hand-computed expectations and latency check
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [31:0] es, input logic ec,
                        input logic eo, input string nm);
    int cnt;
    rdy0 = 1; v0 = 1; a0 = a; b0 = b; cin0 = cin; sub0 = sub;
    @(posedge clk); #1;
    v0 = 0;
    cnt = 1;
    while (!ov0 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (ov0 !== 1'b1 || cnt != LAT0) begin
      errors++;
      $display("FAIL %s_latency: valid=%b after %0d edges, required valid=1 after %0d", nm, ov0, cnt, LAT0);
    end
    checks++;
    if (sum0 !== es || co0 !== ec || of0 !== eo) begin
      errors++;
      $display("FAIL %s_result: summ=%h carry=%b ovf=%b, required summ=%h carry=%b ovf=%b",
               nm, sum0, co0, of0, es, ec, eo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
    run_op(32'h0000_000F, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b0, "add_cin_block");
    run_op(32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h1000_0000, 1'b0, 1'b0, "add_cin_long");
  endtask

  task automatic test_sub();
    run_op(32'd5, 32'd3, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, "sub_5_3");
    run_op(32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_3_5");
    run_op(32'd5, 32'd3, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, "sub_borrow");
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
  endtask

  task automatic test_bubbles();
    logic [3:0]  bpat;
    logic        exp_v;
    logic [31:0] exp_s;
    bpat = 4'b1001;
    rdy0 = 1;
    for (int e = 1; e <= LAT0 + 4; e++) begin
      if (e <= 4) begin
        v0 = bpat[e-1]; a0 = 32'h100 * e; b0 = 32'd1; cin0 = 0; sub0 = 0;
      end else begin
        v0 = 0;
      end
      @(posedge clk); #1;
      exp_v = 1'b0;
      exp_s = '0;
      if (e >= LAT0 && e <= LAT0 + 3) begin
        exp_v = bpat[e-LAT0];
        exp_s = 32'h100 * (e - LAT0 + 1) + 32'd1;
      end
      checks++;
      if (ov0 !== exp_v || (exp_v && sum0 !== exp_s)) begin
        errors++;
        $display("FAIL bubble_edge%0d: valid=%b summ=%h, required valid=%b summ=%h", e, ov0, sum0, exp_v, exp_s);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        q[$];
    exp_t        e;
    logic [5:0]  pat;
    int          sent;
    int          got;
    logic [31:0] na, nb;
    logic        nc, ns;
    logic        stalled;
    logic [31:0] sv_s;
    logic        sv_c, sv_o;
    pat = 6'b010011;
    sent = 0; got = 0;
    na = $urandom; nb = $urandom; nc = 1'($urandom); ns = 1'($urandom);
    for (int c = 0; c < 200 && got < 16; c++) begin
      v0 = (sent < 16); a0 = na; b0 = nb; cin0 = nc; sub0 = ns;
      rdy0 = pat[c % 6];
      #1;
      checks++;
      if (ordy0 !== (~ov0 | rdy0)) begin
        errors++;
        $display("FAIL b2b_ready_c%0d: o_ready=%b, required %b", c, ordy0, ~ov0 | rdy0);
      end
      if (ov0 && rdy0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: result summ=%h with no outstanding op, required none", sum0);
        end else begin
          e = q.pop_front();
          if (sum0 !== e.s || co0 !== e.c || of0 !== e.o) begin
            errors++;
            $display("FAIL b2b_result%0d: summ=%h carry=%b ovf=%b, required summ=%h carry=%b ovf=%b",
                     got, sum0, co0, of0, e.s, e.c, e.o);
          end
        end
        got++;
      end
      stalled = ov0 && !rdy0;
      sv_s = sum0; sv_c = co0; sv_o = of0;
      if (v0 && ordy0) begin
        q.push_back(gold(32, na, nb, nc, ns));
        sent++;
        na = $urandom; nb = $urandom; nc = 1'($urandom); ns = 1'($urandom);
      end
      @(posedge clk); #1;
      if (stalled) begin
        checks++;
        if (ov0 !== 1'b1 || sum0 !== sv_s || co0 !== sv_c || of0 !== sv_o) begin
          errors++;
          $display("FAIL b2b_stall_c%0d: valid=%b summ=%h carry=%b ovf=%b, required 1 %h %b %b",
                   c, ov0, sum0, co0, of0, sv_s, sv_c, sv_o);
        end
      end
    end
    v0 = 0; rdy0 = 1;
    checks++;
    if (got != 16 || sent != 16 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: sent=%0d received=%0d outstanding=%0d, required 16/16/0", sent, got, q.size());
    end
    for (int c = 0; c < LAT0 + 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ov0 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_duplicate_c%0d: valid=%b after drain, required 0", c, ov0);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rdy0 = 1;
    for (int i = 0; i < 5; i++) begin
      v0 = 1; a0 = 32'd100 + i; b0 = i; cin0 = 0; sub0 = 0;
      @(posedge clk); #1;
    end
    v0 = 0;
    checks++;
    if (ov0 !== 1'b1 || sum0 !== 32'h66) begin
      errors++;
      $display("FAIL midrst_pre: valid=%b summ=%h, required valid=1 summ=00000066", ov0, sum0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0 || sum0 !== 32'd0 || co0 !== 1'b0 || of0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b summ=%h carry=%b ovf=%b, required 0/0/0/0", ov0, sum0, co0, of0);
    end
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < LAT0 + 4; c++) begin
      checks++;
      if (ov0 !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale_c%0d: valid=%b summ=%h, required valid=0", c, ov0, sum0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sweep();
    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e;
    logic [31:0] ta, tb;
    logic        tc, ts;
    rdy1 = 1; rdy2 = 1;
    for (int i = 0; i < 1000 + LAT2 + 2; i++) begin
      if (i < 1000) begin
        ta = rnd_op(32); tb = rnd_op(32); tc = 1'($urandom); ts = 1'($urandom);
        v1 = 1; a1 = ta; b1 = tb; cin1 = tc; sub1 = ts;
        e = gold(32, ta, tb, tc, ts); e.acc = cyc + 1;
        q1.push_back(e);
        ta = rnd_op(16); tb = rnd_op(16); tc = 1'($urandom); ts = 1'($urandom);
        v2 = 1; a2 = ta[15:0]; b2 = tb[15:0]; cin2 = tc; sub2 = ts;
        e = gold(16, ta, tb, tc, ts); e.acc = cyc + 1;
        q2.push_back(e);
      end else begin
        v1 = 0; v2 = 0;
      end
      @(posedge clk); #1;
      if (ov1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sweep1_extra: summ=%h with no outstanding op", sum1);
        end else begin
          e = q1.pop_front();
          if (sum1 !== e.s || co1 !== e.c || of1 !== e.o) begin
            errors++;
            $display("FAIL sweep1_result: summ=%h carry=%b ovf=%b, required summ=%h carry=%b ovf=%b",
                     sum1, co1, of1, e.s, e.c, e.o);
          end
          checks++;
          if (cyc - e.acc != LAT1 - 1) begin
            errors++;
            $display("FAIL sweep1_latency: %0d edges, required %0d", cyc - e.acc + 1, LAT1);
          end
        end
      end
      if (ov2) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL sweep2_extra: summ=%h with no outstanding op", sum2);
        end else begin
          e = q2.pop_front();
          if ({16'd0, sum2} !== e.s || co2 !== e.c || of2 !== e.o) begin
            errors++;
            $display("FAIL sweep2_result: summ=%h carry=%b ovf=%b, required summ=%h carry=%b ovf=%b",
                     sum2, co2, of2, e.s[15:0], e.c, e.o);
          end
          checks++;
          if (cyc - e.acc != LAT2 - 1) begin
            errors++;
            $display("FAIL sweep2_latency: %0d edges, required %0d", cyc - e.acc + 1, LAT2);
          end
        end
      end
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL sweep_lost: outstanding %0d / %0d ops, required 0 / 0", q1.size(), q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_bubbles();
    test_back_to_back();
    test_reset_midstream();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/csla_pipe_adder.md
# csla_pipe_adder

Parametrised, pipelined carry-select adder/subtractor for the SHA-256 datapath's modular-addition chain. Operands are split into BLOCK-bit carry-select blocks: the lowest block ripples, every other block computes sums for carry-in 0 and 1 and muxes on the incoming carry. Registers are inserted every BLOCKS_PER_STAGE blocks, with operand skew and sum de-skew registers, so one operation is accepted per cycle. A valid/ready handshake with whole-pipeline stall lets it sit between the message scheduler and the compression round logic.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of BLOCK.
- BLOCK, 4: bits per carry-select block; must be ≥ 2.
- BLOCKS_PER_STAGE, 2: blocks evaluated per pipeline stage; NBLK = WIDTH/BLOCK must be a multiple of it.
- Derived: NBLK = WIDTH/BLOCK; LAT = NBLK/BLOCKS_PER_STAGE (defaults: 8 blocks, LAT = 4).
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input operation valid.
- o_ready  out  1  block can accept; o_ready = ~o_valid | i_ready (combinational).
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_carry  in  1  carry-in for add; borrow-in for subtract.
- i_sub  in  1  0 = A+B+cin, 1 = A−B−borrow.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_summ  out  WIDTH  result modulo 2^WIDTH.
- o_carry  out  1  raw carry-out of the MSB block. In subtract mode, 1 means no borrow.
- o_overflow  out  1  two's-complement signed overflow of the selected operation.

## Operation
- Effective operands:
  - b' = i_b XOR {WIDTH{i_sub}}.
  - cin' = i_carry XOR i_sub.
  - Result = i_a + b' + cin', truncated to WIDTH bits; the carry out of bit WIDTH−1 is o_carry.
  - Subtract example: 5 − 3 − 0 gives 5 + ~3 + 1.
- Block 0 is a plain ripple block using cin'. Blocks 1..NBLK−1 each contain two ripple sums (cin = 0 and cin = 1); the incoming block carry selects both sum and carry-out.
- Stage k (k = 0..LAT−1) evaluates blocks k·BLOCKS_PER_STAGE .. (k+1)·BLOCKS_PER_STAGE−1. Inside a stage, block carries chain combinationally.
- Stage k registers:
  - its carry-out;
  - the sum bits produced so far;
  - the not-yet-consumed operand bits;
  - i_sub;
  - a valid bit.
- Stage k+1 consumes those registers. Operand bits of higher blocks travel through skew registers until their stage.
- o_overflow = carry into the MSB XOR carry out of the MSB. It is computed in the last stage.
- Pipeline advance enable: en = ~o_valid | i_ready, shared by every stage (global stall, no bubble compression).
  - When en = 1: every stage loads from its predecessor; stage 0 loads i_valid.
  - When en = 0: every register holds.
- Handshake:
  - An input is accepted on a cycle with i_valid & o_ready.
  - A result is consumed on a cycle with o_valid & i_ready.
  - Bubbles (i_valid = 0 while en = 1) propagate as valid = 0 stages.
- Data registers may load on en regardless of valid. Outputs with o_valid = 0 are don't-care, except after reset.

## Timing
- Reset, asynchronous, while i_rst_n = 0:
  - all valid bits and o_valid = 0;
  - o_summ = 0, o_carry = 0, o_overflow = 0;
  - all skew and carry registers = 0.
- Reset mid-operation discards every in-flight operation. The first result after release comes only from an input accepted after release.
- Latency: an input accepted on edge n appears on o_valid/o_summ after edge n+LAT−1, provided no stall intervenes. Default: visible 4 cycles after acceptance.
- Each stall cycle (o_valid & ~i_ready) adds exactly one cycle to every in-flight operation. o_summ, o_carry and o_overflow stay stable while stalled.
- Throughput: 1 op/cycle while i_ready = 1.
- Simultaneous accept and consume in one cycle is legal. Valid, stalled results with o_ready = 0 must not be lost or duplicated.
- Critical path per stage: one ripple block plus (BLOCKS_PER_STAGE−1) mux levels.

## Test plan
- Reset: assert i_rst_n = 0 mid-stream with 3 ops in flight → o_valid = 0 and o_summ = 0 immediately. After release, no stale results appear.
- Add, defaults, i_ready = 1:
  - a = 0xFFFFFFFF, b = 0x00000001, cin = 0 → 4 cycles after acceptance, o_summ = 0x00000000, o_carry = 1, o_overflow = 0.
  - a = 0x7FFFFFFF, b = 1 → o_summ = 0x80000000, o_overflow = 1, o_carry = 0.
- Subtract: a = 5, b = 3, i_sub = 1, i_carry = 0 → o_summ = 0x00000002, o_carry = 1. Then a = 3, b = 5 → o_summ = 0xFFFFFFFE, o_carry = 0. Then a = 5, b = 3, i_carry = 1 → o_summ = 0x00000001.
- Back-to-back stream of 16 random ops with i_ready toggling in the pattern 1,1,0,0,1,0,… → results in order and equal to the golden model. No loss or duplication. Outputs are stable during every stall cycle. o_ready equals ~o_valid | i_ready on every cycle.
- Bubbles: i_valid pattern 1,0,0,1 → o_valid pattern 1,0,0,1, delayed by LAT cycles.
- Parameter sweep:
  - WIDTH = 32, BLOCK = 8, BLOCKS_PER_STAGE = 4 (LAT = 1);
  - WIDTH = 16, BLOCK = 2, BLOCKS_PER_STAGE = 1 (LAT = 8).
  - For each: 1000 random ops, including operands 0 and 2^WIDTH−1 → bit-exact against the golden model, latency equal to LAT.
